// File: rtl/cp0_timer_intc.sv
// CP0 Count/Compare timer with NUM_CMP compare channels, Count prescaler and debug stall,
// hardware interrupt synchronisers and a registered, prioritised interrupt request.
module cp0_timer_intc #(
  parameter int NUM_CMP     = 2,
  parameter int DIV_LOG2    = 1,
  parameter int HW_INT      = 6,
  parameter int TI_LINE     = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [3:0]        wr_addr,
  input  logic [31:0]       data_i,
  input  logic [3:0]        rd_addr,
  output logic [31:0]       data_o,
  input  logic              count_stall,
  input  logic [HW_INT-1:0] hw_int_i,
  input  logic [1:0]        sw_int_i,
  input  logic [HW_INT+1:0] im_i,
  input  logic              allow_int,
  output logic              timer_int,
  output logic [HW_INT+1:0] ip_o,
  output logic              int_req,
  output logic [2:0]        int_num
);
  localparam int IPW = HW_INT + 2;
  localparam int PW  = (DIV_LOG2 > 0) ? DIV_LOG2 : 1;

  logic [31:0]        count_q, count_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic [31:0]        cmp_q [NUM_CMP];
  logic [31:0]        cmp_d [NUM_CMP];
  logic [NUM_CMP-1:0] en_q, en_d;
  logic [NUM_CMP-1:0] pend_q, pend_d;
  logic [NUM_CMP-1:0] eq_prev_q;
  logic [NUM_CMP-1:0] eq_s;
  logic [NUM_CMP-1:0] cmp_wr_s;
  logic [HW_INT-1:0]  sync_q [SYNC_STAGES];
  logic               int_req_q, int_req_d;
  logic [2:0]         int_num_q, int_num_d;
  logic               count_wr_s, pend_wr_s, en_wr_s, tick_s;
  logic [IPW-1:0]     masked_s;

  // Write strobe decode
  always_comb begin
    count_wr_s = we && (wr_addr == 4'd0);
    pend_wr_s  = we && (wr_addr == 4'd8);
    en_wr_s    = we && (wr_addr == 4'd9);
    for (int k = 0; k < NUM_CMP; k++) begin
      cmp_wr_s[k] = we && (wr_addr == 4'(k + 1));
    end
  end

  // Prescaler: tick on wrap to zero; a Count write restarts the period
  always_comb begin
    if (DIV_LOG2 == 0) begin
      tick_s = ~count_stall;
      pre_d  = '0;
    end else begin
      tick_s = ~count_stall && (pre_q == {PW{1'b1}});
      if (count_wr_s) begin
        pre_d = '0;
      end else if (count_stall) begin
        pre_d = pre_q;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // Count next state; software load beats a tick
  always_comb begin
    if (count_wr_s) begin
      count_d = data_i;
    end else if (tick_s) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Per-channel match edge detect, pending set/clear (clear wins), enables
  always_comb begin
    for (int k = 0; k < NUM_CMP; k++) begin
      eq_s[k]  = (count_q == cmp_q[k]);
      cmp_d[k] = cmp_wr_s[k] ? data_i : cmp_q[k];
      if (cmp_wr_s[k] || (pend_wr_s && data_i[k])) begin
        pend_d[k] = 1'b0;
      end else begin
        pend_d[k] = pend_q[k] | (eq_s[k] & ~eq_prev_q[k] & en_q[k]);
      end
    end
    en_d = en_wr_s ? data_i[NUM_CMP-1:0] : en_q;
  end

  assign timer_int = |(pend_q & en_q);

  // Cause.IP merge and next request / priority encode
  always_comb begin
    ip_o          = {sync_q[SYNC_STAGES-1], sw_int_i};
    ip_o[TI_LINE] = ip_o[TI_LINE] | timer_int;
    masked_s      = ip_o & im_i;
    int_req_d     = allow_int & (|masked_s);
    int_num_d     = 3'd0;
    for (int i = 0; i < IPW; i++) begin
      int_num_d = masked_s[i] ? 3'(i) : int_num_d;
    end
  end

  // Register read mux
  always_comb begin
    data_o = 32'd0;
    case (rd_addr)
      4'd0:    data_o = count_q;
      4'd8:    data_o = {{(32-NUM_CMP){1'b0}}, pend_q};
      4'd9:    data_o = {{(32-NUM_CMP){1'b0}}, en_q};
      default: begin
        for (int k = 0; k < NUM_CMP; k++) begin
          data_o = (rd_addr == 4'(k + 1)) ? cmp_q[k] : data_o;
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= 32'd0;
      pre_q     <= '0;
      en_q      <= '1;
      pend_q    <= '0;
      eq_prev_q <= '0;
      int_req_q <= 1'b0;
      int_num_q <= 3'd0;
      for (int k = 0; k < NUM_CMP; k++) begin
        cmp_q[k] <= 32'hFFFF_FFFF;
      end
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      count_q   <= count_d;
      pre_q     <= pre_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
      eq_prev_q <= eq_s;
      int_req_q <= int_req_d;
      int_num_q <= int_num_d;
      for (int k = 0; k < NUM_CMP; k++) begin
        cmp_q[k] <= cmp_d[k];
      end
      sync_q[0] <= hw_int_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign int_req = int_req_q;
  assign int_num = int_num_q;

endmodule

// File: tb/tb_cp0_timer_intc.sv
// Self-checking bench for cp0_timer_intc: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the register/interrupt rules.
module tb_cp0_timer_intc;
  localparam int NC   = 2;
  localparam int DV   = 1;
  localparam int HW   = 6;
  localparam int TL   = 7;
  localparam int SS   = 2;
  localparam int IPW  = HW + 2;
  localparam int DIVN = 1 << DV;

  logic           clk = 1'b0;
  logic           rst_n, we, count_stall, allow_int;
  logic [3:0]     wr_addr, rd_addr;
  logic [31:0]    data_i, data_o;
  logic [HW-1:0]  hw_int_i;
  logic [1:0]     sw_int_i;
  logic [IPW-1:0] im_i, ip_o;
  logic           timer_int, int_req;
  logic [2:0]     int_num;

  int n_total = 0;
  int n_bad   = 0;

  // Model state
  logic [31:0]   m_count;
  int unsigned   m_act;
  logic [31:0]   m_cmp [NC];
  logic [NC-1:0] m_en, m_pend, m_eqprev;
  logic [HW-1:0] m_sync [SS];
  logic          m_req;
  logic [2:0]    m_num;

  cp0_timer_intc #(.NUM_CMP(NC), .DIV_LOG2(DV), .HW_INT(HW), .TI_LINE(TL), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .data_i(data_i),
    .rd_addr(rd_addr), .data_o(data_o), .count_stall(count_stall),
    .hw_int_i(hw_int_i), .sw_int_i(sw_int_i), .im_i(im_i), .allow_int(allow_int),
    .timer_int(timer_int), .ip_o(ip_o), .int_req(int_req), .int_num(int_num)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic m_timer();
    return |(m_pend & m_en);
  endfunction

  function automatic logic [IPW-1:0] m_ip();
    logic [IPW-1:0] v;
    v = {m_sync[SS-1], sw_int_i};
    if (m_timer()) v[TL] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    if (a == 4'd0) return m_count;
    if (a >= 4'd1 && a <= 4'(NC)) return m_cmp[int'(a) - 1];
    if (a == 4'd8) return {30'd0, m_pend};
    if (a == 4'd9) return {30'd0, m_en};
    return 32'd0;
  endfunction

  // One clock: advance the model using the values present before the edge
  task automatic cyc();
    logic [NC-1:0]  eq, pn;
    logic [IPW-1:0] msk;
    logic [2:0]     top;
    msk = m_ip() & im_i;
    top = 3'd0;
    for (int i = IPW - 1; i >= 0; i--) begin
      if (msk[i]) begin
        top = 3'(i);
        break;
      end
    end
    for (int k = 0; k < NC; k++) eq[k] = (m_count == m_cmp[k]);
    @(posedge clk);
    if (!rst_n) begin
      m_count = 32'd0; m_act = 0; m_en = '1; m_pend = '0; m_eqprev = '0;
      m_req = 1'b0; m_num = 3'd0;
      for (int k = 0; k < NC; k++) m_cmp[k] = 32'hFFFF_FFFF;
      for (int s = 0; s < SS; s++) m_sync[s] = '0;
    end else begin
      m_req = allow_int & (|msk);
      m_num = top;
      pn = m_pend | (eq & ~m_eqprev & m_en);
      if (we && wr_addr == 4'd0) begin
        m_count = data_i;
        m_act = 0;
      end else if (!count_stall) begin
        m_act++;
        if (m_act % DIVN == 0) m_count = m_count + 32'd1;
      end
      if (we && wr_addr >= 4'd1 && wr_addr <= 4'(NC)) begin
        m_cmp[int'(wr_addr) - 1] = data_i;
        pn[int'(wr_addr) - 1] = 1'b0;
      end
      if (we && wr_addr == 4'd8) pn = pn & ~data_i[NC-1:0];
      if (we && wr_addr == 4'd9) m_en = data_i[NC-1:0];
      m_pend = pn;
      m_eqprev = eq;
      for (int s = SS - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
      m_sync[0] = hw_int_i;
    end
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; wr_addr = a; data_i = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0]  ra [5];
    logic [31:0] rv [5];
    ra = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd9};
    rv = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd3};
    rst_n = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      rd_addr = ra[i];
      #1;
      n_total++;
      if (data_o !== rv[i]) begin
        n_bad++; $display("FAIL reset_reg[%0d]: got %h want %h", ra[i], data_o, rv[i]);
      end
    end
    n_total++;
    if ({timer_int, ip_o, int_req, int_num} !== 13'd0) begin
      n_bad++; $display("FAIL reset_outs: got %b want 0", {timer_int, ip_o, int_req, int_num});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_timer_match();
    int waited;
    bit found;
    im_i = 8'h80; allow_int = 1'b1; rd_addr = 4'd8;
    wr(4'd0, 32'd10);
    wr(4'd1, 32'd14);
    waited = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      waited++;
      n_total++;
      if (timer_int !== m_timer()) begin
        n_bad++; $display("FAIL match_timer: got %b want %b", timer_int, m_timer());
      end
      if (timer_int === 1'b1) found = 1'b1;
    end
    n_total++;
    if (!found || waited != 8) begin
      n_bad++; $display("FAIL match_latency: got %0d want 8", waited);
    end
    n_total++;
    if (data_o !== 32'd1 || int_req !== 1'b0) begin
      n_bad++; $display("FAIL match_pend: got pend=%h req=%b want 1/0", data_o, int_req);
    end
    cyc();
    n_total++;
    if (int_req !== 1'b1 || int_num !== 3'd7) begin
      n_bad++; $display("FAIL match_req: got %b/%0d want 1/7", int_req, int_num);
    end
    wr(4'd1, 32'd1000);
    n_total++;
    if (timer_int !== 1'b0 || int_req !== 1'b1 || data_o !== 32'd0) begin
      n_bad++; $display("FAIL cmpwr_clear: got ti=%b req=%b pend=%h want 0/1/0", timer_int, int_req, data_o);
    end
    cyc();
    n_total++;
    if (int_req !== 1'b0) begin
      n_bad++; $display("FAIL cmpwr_req: got %b want 0", int_req);
    end
  endtask

  task automatic test_wrap();
    rd_addr = 4'd8;
    wr(4'd2, 32'd0);
    wr(4'd0, 32'hFFFF_FFFE);
    for (int i = 0; i < 16; i++) begin
      cyc();
      n_total++;
      if (data_o !== m_read(4'd8)) begin
        n_bad++; $display("FAIL wrap_pend: got %h want %h", data_o, m_read(4'd8));
      end
      if (m_pend[1]) begin
        count_stall = 1'b1;
        break;
      end
    end
    n_total++;
    if (data_o !== 32'd2) begin
      n_bad++; $display("FAIL wrap_set: got %h want 2", data_o);
    end
    wr(4'd8, 32'd2);
    for (int i = 0; i < 6; i++) cyc();
    n_total++;
    if (data_o !== 32'd0) begin
      n_bad++; $display("FAIL stall_noreset: got %h want 0", data_o);
    end
    rd_addr = 4'd0;
    #1;
    n_total++;
    if (data_o !== 32'd0) begin
      n_bad++; $display("FAIL stall_count: got %h want 0", data_o);
    end
    count_stall = 1'b0;
  endtask

  task automatic test_w1c_race();
    rd_addr = 4'd8;
    wr(4'd1, 32'd50);
    wr(4'd0, 32'd50);
    wr(4'd8, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_total++;
      if (data_o !== 32'd0 || timer_int !== 1'b0) begin
        n_bad++; $display("FAIL w1c_race: got pend=%h ti=%b want 0/0", data_o, timer_int);
      end
    end
  endtask

  task automatic test_en_off();
    rd_addr = 4'd8;
    wr(4'd9, 32'd2);
    wr(4'd1, 32'd70);
    wr(4'd0, 32'd66);
    for (int i = 0; i < 16; i++) begin
      cyc();
      n_total++;
      if (timer_int !== 1'b0 || data_o !== 32'd0) begin
        n_bad++; $display("FAIL en_off: got ti=%b pend=%h want 0/0", timer_int, data_o);
      end
    end
    rd_addr = 4'd0;
    #1;
    n_total++;
    if (data_o !== m_read(4'd0)) begin
      n_bad++; $display("FAIL en_off_count: got %h want %h", data_o, m_read(4'd0));
    end
    wr(4'd9, 32'd3);
    wr(4'd1, 32'hFFFF_FFFF);
    wr(4'd2, 32'hFFFF_FFFF);
  endtask

  task automatic test_hw_int();
    im_i = 8'hFF; sw_int_i = 2'b01; allow_int = 1'b1;
    hw_int_i = 6'b000100;
    cyc();
    cyc();
    n_total++;
    if (int_num !== 3'd0 || ip_o !== 8'h11) begin
      n_bad++; $display("FAIL hw_sync: got num=%0d ip=%h want 0/11", int_num, ip_o);
    end
    cyc();
    n_total++;
    if (int_num !== 3'd4 || int_req !== 1'b1) begin
      n_bad++; $display("FAIL hw_num: got %0d/%b want 4/1", int_num, int_req);
    end
    hw_int_i = '0;
    im_i = 8'h01;
    cyc();
    n_total++;
    if (int_num !== 3'd0 || int_req !== 1'b1) begin
      n_bad++; $display("FAIL im_mask: got %0d/%b want 0/1", int_num, int_req);
    end
    allow_int = 1'b0;
    cyc();
    n_total++;
    if (int_req !== 1'b0) begin
      n_bad++; $display("FAIL allow_off: got %b want 0", int_req);
    end
    sw_int_i = 2'b00;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      we = ($urandom_range(0, 3) == 0);
      wr_addr = 4'($urandom_range(0, 15));
      case (wr_addr)
        4'd0:       data_i = m_cmp[$urandom_range(0, NC - 1)] - 32'($urandom_range(0, 6));
        4'd1, 4'd2: data_i = m_count + 32'($urandom_range(0, 8));
        4'd8:       data_i = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'd0;
        4'd9:       data_i = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'd3;
        default:    data_i = 32'($urandom);
      endcase
      count_stall = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) hw_int_i = HW'($urandom);
      if ($urandom_range(0, 15) == 0) sw_int_i = 2'($urandom);
      if ($urandom_range(0, 15) == 0) im_i = IPW'($urandom);
      if ($urandom_range(0, 15) == 0) allow_int = 1'($urandom);
      rd_addr = 4'($urandom_range(0, 15));
      cyc();
      n_total++;
      if (data_o !== m_read(rd_addr)) begin
        n_bad++; $display("FAIL rnd_read[%0d] cyc %0d: got %h want %h", rd_addr, i, data_o, m_read(rd_addr));
      end
      n_total++;
      if (timer_int !== m_timer() || ip_o !== m_ip()) begin
        n_bad++; $display("FAIL rnd_ip cyc %0d: got %b/%h want %b/%h", i, timer_int, ip_o, m_timer(), m_ip());
      end
      n_total++;
      if (int_req !== m_req || int_num !== m_num) begin
        n_bad++; $display("FAIL rnd_req cyc %0d: got %b/%0d want %b/%0d", i, int_req, int_num, m_req, m_num);
      end
    end
    we = 1'b0;
  endtask

  task automatic test_reset_mid();
    count_stall = 1'b0; sw_int_i = 2'b00; hw_int_i = '0;
    im_i = 8'hFF; allow_int = 1'b1;
    wr(4'd9, 32'd3);
    wr(4'd0, 32'd5);
    wr(4'd1, 32'd5);
    cyc();
    n_total++;
    if (timer_int !== 1'b1) begin
      n_bad++; $display("FAIL mid_pre: got %b want 1", timer_int);
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    rd_addr = 4'd8;
    #1;
    n_total++;
    if (data_o !== 32'd0 || timer_int !== 1'b0 || int_req !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset: got pend=%h ti=%b req=%b want 0/0/0", data_o, timer_int, int_req);
    end
    rd_addr = 4'd1;
    #1;
    n_total++;
    if (data_o !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL mid_cmp: got %h want ffffffff", data_o);
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; wr_addr = 4'd0; data_i = 32'd0; rd_addr = 4'd0;
    count_stall = 1'b0; hw_int_i = '0; sw_int_i = 2'b00; im_i = '0; allow_int = 1'b0;
    test_reset();
    test_timer_match();
    test_wrap();
    test_w1c_race();
    test_en_off();
    test_hw_int();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0_timer_intc.md
# cp0_timer_intc

Parametrised Count/Compare timer and interrupt-pending controller for the CP0 of the MIPS core. It generalises the single Count/Compare pair to NUM_CMP compare channels with per-channel enable and write-1-to-clear pending bits, and adds a Count prescaler, a debug stall and hardware-interrupt synchronisers. It also merges timer, hardware and software sources into the Cause.IP vector and produces a registered, prioritised interrupt request to the exception unit.

## Interface
- NUM_CMP, 2, number of compare channels (1..4)
- DIV_LOG2, 1, Count increments once every 2^DIV_LOG2 cycles (0 = every cycle)
- HW_INT, 6, number of hardware interrupt pins; IP width is HW_INT+2
- TI_LINE, 7, IP bit the timer interrupt is ORed into (2..HW_INT+1)
- SYNC_STAGES, 2, synchroniser depth for hw_int_i (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- we  in  1  register write strobe
- wr_addr  in  4  write register select
- data_i  in  32  write data
- rd_addr  in  4  read register select
- data_o  out  32  read data, combinational
- count_stall  in  1  freeze Count and prescaler (debug halt)
- hw_int_i  in  HW_INT  asynchronous level hardware interrupts
- sw_int_i  in  2  Cause.IP[1:0] software interrupt bits
- im_i  in  HW_INT+2  Status.IM
- allow_int  in  1  IE=1, EXL=0, ERL=0
- timer_int  out  1  OR of (pend & en) over all channels
- ip_o  out  HW_INT+2  live IP vector for Cause reads
- int_req  out  1  registered interrupt request
- int_num  out  3  registered index of highest masked pending IP bit

## Operation
- Register map:
  - 0: Count.
  - 1..NUM_CMP: Compare[k-1].
  - 8: PEND. Bits [NUM_CMP-1:0] are read as pending; writing 1 to a bit clears it.
  - 9: EN. Bits [NUM_CMP-1:0] are read/write channel enables.
  - Other addresses read 0 and ignore writes.
- Reset values:
  - Count = 0, prescaler = 0.
  - Compare = 0xFFFFFFFF.
  - EN = all ones, PEND = 0.
  - Synchronisers = 0.
  - timer_int = 0, int_req = 0, int_num = 0.
- Prescaler:
  - DIV_LOG2-bit up-counter.
  - A tick occurs when it wraps to 0 (every cycle if DIV_LOG2 = 0).
  - On a tick, Count <= Count + 1, mod 2^32. 0xFFFFFFFF wraps to 0 with no side effect.
  - count_stall=1 holds both the prescaler and Count.
- Count write: loads data_i and clears the prescaler. It takes priority over a tick in the same cycle.
- Match for channel k: eq_k = (Count == Compare[k]).
  - A registered copy eq_d_k is kept.
  - pend[k] sets on eq_k & ~eq_d_k & en[k], i.e. the rising edge of equality.
  - Compare = 0 is a valid match value.
  - The match is level-to-edge, so a stalled Count sitting at Compare sets pend once only.
- pend[k] clears on a write to Compare[k] or a W1C write to PEND. A clear wins over a set in the same cycle.
- Writing EN does not clear pend; timer_int masks with en.
- Loading Count to equal Compare[k] sets pend[k] on the next cycle via the edge rule.
- ip_o = {hw_sync[HW_INT-1:0], sw_int_i}, with timer_int ORed into bit TI_LINE.
- Request logic, registered each cycle:
  - m = ip_o & im_i.
  - int_req <= allow_int & |m.
  - int_num <= highest set bit index of m, or 0 if m = 0.

## Timing
- Count write at edge N: data_o shows the new Count after N. The first tick is 2^DIV_LOG2 cycles later.
- With DIV_LOG2 = 0, Count reaches Compare at edge N:
  - pend and timer_int are high after N+1.
  - int_req is high after N+2 (if enabled and unmasked).
- Compare write at edge N: timer_int is low after N. int_req falls after N+1.
- hw_int_i rising:
  - ip_o reflects it after SYNC_STAGES edges.
  - int_req follows one edge later.
- A change in im_i, sw_int_i or allow_int reaches int_req/int_num at the next edge.
- Reset asserted mid-operation: all state returns to reset values at that edge, and pending bits are lost.

## Test plan
- Reset, then read all registers.
  - Count = 0, Compare[0] = 0xFFFFFFFF, EN = 0x3, PEND = 0.
  - All outputs are 0.
- DIV_LOG2 = 1, write Count = 10, Compare[0] = 14, IM[7] = 1, allow_int = 1.
  - pend[0] sets after 8 cycles.
  - int_req = 1 with int_num = 7 one cycle later.
  - Writing Compare[0] clears both in the next cycle.
- Count = 0xFFFFFFFE, Compare[1] = 0.
  - Count wraps and pend[1] sets.
  - With count_stall held at Count = 0, there is no re-set after W1C to PEND.
- W1C to PEND in the same cycle as a match edge: pend stays 0.
- EN = 0 for channel 0: a match leaves pend[0] = 0 and timer_int = 0.
- Pulse hw_int_i[2] (IP4) with sw_int_i[0] = 1 and im_i = 0xFF.
  - int_num = 4 after SYNC_STAGES+1 cycles.
  - With im_i = 0x01, int_num = 0.
  - With allow_int = 0, int_req = 0.
